// File: rtl/alu_seq_pkg.sv
// Shared codes for the sequential ALU: function codes, mode codes, FSM encodings
// and the packed flag bundle carried from the datapath to the output registers.
package alu_seq_pkg;

  localparam logic [1:0] ALU_MODE_LOGIC = 2'd0;
  localparam logic [1:0] ALU_MODE_SHIFT = 2'd1;
  localparam logic [1:0] ALU_MODE_MUL   = 2'd2;
  localparam logic [1:0] ALU_MODE_RSVD  = 2'd3;

  localparam logic [4:0] ALU_F_A   = 5'd0;
  localparam logic [4:0] ALU_F_NOT = 5'd1;
  localparam logic [4:0] ALU_F_AND = 5'd2;
  localparam logic [4:0] ALU_F_OR  = 5'd3;
  localparam logic [4:0] ALU_F_XOR = 5'd4;
  localparam logic [4:0] ALU_F_ADD = 5'd5;
  localparam logic [4:0] ALU_F_SUB = 5'd6;

  localparam logic [4:0] ALU_F_SHIFT_SHL = 5'd0;
  localparam logic [4:0] ALU_F_SHIFT_SHR = 5'd1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_MUL  = 2'd2;

  typedef struct packed {
    logic c;
    logic z;
    logic v;
    logic n;
  } alu_flags_t;

endpackage

// File: rtl/alu_seq_mul_iter.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, WIDTH cycles.
// done is high during the final iteration; prod then holds the finished product.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic               run_p1;
  logic [CW-1:0]      cnt_p1;
  logic [WIDTH-1:0]   mcand_p1;
  logic [2*WIDTH-1:0] acc_p1;
  logic [WIDTH:0]     part;

  // acc holds {partial high, remaining multiplier bits}; each step adds and shifts right
  always_comb begin
    part = {1'b0, acc_p1[2*WIDTH-1:WIDTH]} + (acc_p1[0] ? {1'b0, mcand_p1} : '0);
    prod = {part, acc_p1[WIDTH-1:1]};
    done = run_p1 && (cnt_p1 == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_p1 <= 1'b0;
      cnt_p1 <= '0;
    end else if (start && !run_p1) begin
      run_p1 <= 1'b1;
      cnt_p1 <= CW'(WIDTH);
    end else if (run_p1) begin
      cnt_p1 <= cnt_p1 - CW'(1);
      if (done) run_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start && !run_p1) begin
      mcand_p1 <= a;
      acc_p1   <= {{WIDTH{1'b0}}, b};
    end else if (run_p1) begin
      acc_p1 <= prod;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with 74181-style logic/arithmetic, shifts and an iterative multiplier,
// driven by a start/busy/done handshake from the control unit.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [4:0]       f,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi,
  output logic             cout,
  output logic             zout,
  output logic             vout,
  output logic             nout,
  output logic             err,
  output logic             busy,
  output logic             done
);

  function automatic logic [WIDTH:0] shl_out(input logic [WIDTH-1:0] x, input logic [SHW-1:0] s);
    return {1'b0, x} << s;
  endfunction

  // Guard bit below the LSB catches the last bit shifted out on a right shift
  function automatic logic [WIDTH:0] shr_out(input logic [WIDTH-1:0] x, input logic [SHW-1:0] s);
    return {x, 1'b0} >> s;
  endfunction

  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  logic [1:0]         state_p1;
  logic               vld_p1;
  logic [WIDTH-1:0]   y_p1;
  logic [WIDTH-1:0]   hi_p1;
  alu_flags_t         fl_p1;
  logic               err_p1;

  logic [WIDTH-1:0]   sc_y;
  alu_flags_t         sc_fl;
  logic               sc_err;
  logic [WIDTH:0]     sc_sum;
  logic [WIDTH:0]     sc_sh;

  logic               mul_go;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  alu_flags_t         mul_fl;

  always_comb begin
    sc_y   = a;
    sc_fl  = '0;
    sc_err = 1'b0;
    sc_sum = '0;
    sc_sh  = '0;
    case (mode)
      ALU_MODE_LOGIC: begin
        case (f)
          ALU_F_A:   sc_y = a;
          ALU_F_NOT: sc_y = ~a;
          ALU_F_AND: sc_y = a & b;
          ALU_F_OR:  sc_y = a | b;
          ALU_F_XOR: sc_y = a ^ b;
          ALU_F_ADD: begin
            sc_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            sc_y    = sc_sum[WIDTH-1:0];
            sc_fl.c = sc_sum[WIDTH];
            sc_fl.v = add_ovf(a[WIDTH-1], b[WIDTH-1], sc_sum[WIDTH-1]);
          end
          ALU_F_SUB: begin
            sc_sum  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, cin};
            sc_y    = sc_sum[WIDTH-1:0];
            sc_fl.c = sc_sum[WIDTH];
            sc_fl.v = add_ovf(a[WIDTH-1], ~b[WIDTH-1], sc_sum[WIDTH-1]);
          end
          default:   sc_err = 1'b1;
        endcase
      end
      ALU_MODE_SHIFT: begin
        case (f)
          ALU_F_SHIFT_SHL: begin
            sc_sh   = shl_out(a, b[SHW-1:0]);
            sc_y    = sc_sh[WIDTH-1:0];
            sc_fl.c = sc_sh[WIDTH];
          end
          ALU_F_SHIFT_SHR: begin
            sc_sh   = shr_out(a, b[SHW-1:0]);
            sc_y    = sc_sh[WIDTH:1];
            sc_fl.c = sc_sh[0];
          end
          default: sc_err = 1'b1;
        endcase
      end
      ALU_MODE_MUL:  sc_y   = a;
      ALU_MODE_RSVD: sc_err = 1'b1;
      default:       sc_err = 1'b1;
    endcase
    sc_fl.z = (sc_y == '0);
    sc_fl.n = sc_y[WIDTH-1];
  end

  always_comb begin
    mul_fl   = '0;
    mul_fl.c = (mul_prod[2*WIDTH-1:WIDTH] != '0);
    mul_fl.z = (mul_prod == '0);
    mul_fl.n = mul_prod[2*WIDTH-1];
  end

  assign mul_go = start && (state_p1 != ST_MUL) && (mode == ALU_MODE_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (mul_go),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  // Stage p1: output registers, loaded on accept (single-cycle) or on the final multiply step
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1 <= ST_IDLE;
      vld_p1   <= 1'b0;
      y_p1     <= '0;
      hi_p1    <= '0;
      fl_p1    <= '0;
      err_p1   <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      case (state_p1)
        ST_MUL: begin
          if (mul_done) begin
            state_p1 <= ST_IDLE;
            vld_p1   <= 1'b1;
            y_p1     <= mul_prod[WIDTH-1:0];
            hi_p1    <= mul_prod[2*WIDTH-1:WIDTH];
            fl_p1    <= mul_fl;
            err_p1   <= 1'b0;
          end
        end
        default: begin
          if (start) begin
            if (mode == ALU_MODE_MUL) begin
              state_p1 <= ST_MUL;
            end else begin
              state_p1 <= ST_EXEC;
              vld_p1   <= 1'b1;
              y_p1     <= sc_y;
              hi_p1    <= '0;
              fl_p1    <= sc_fl;
              err_p1   <= sc_err;
            end
          end else begin
            state_p1 <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign y    = y_p1;
  assign hi   = hi_p1;
  assign cout = fl_p1.c;
  assign zout = fl_p1.z;
  assign vout = fl_p1.v;
  assign nout = fl_p1.n;
  assign err  = err_p1;
  assign busy = (state_p1 == ST_MUL);
  assign done = vld_p1;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=16: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [4:0]   f = 5'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic [W-1:0] y, hi;
  logic         cout, zout, vout, nout, err, busy, done;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct packed {
    logic [15:0] y;
    logic [15:0] hi;
    logic        c, z, v, n, e;
  } exp_t;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .f(f),
    .a(a), .b(b), .cin(cin), .y(y), .hi(hi), .cout(cout), .zout(zout),
    .vout(vout), .nout(nout), .err(err), .busy(busy), .done(done)
  );

  function automatic exp_t model(input logic [1:0] m, input logic [4:0] fc,
                                 input logic [15:0] ta, input logic [15:0] tb,
                                 input logic ci);
    exp_t   e;
    longint r;
    int     sr;
    int     s;
    e  = '0;
    e.y = ta;
    r  = 0;
    sr = 0;
    s  = int'(tb[3:0]);
    case (m)
      ALU_MODE_LOGIC: begin
        if (fc == ALU_F_A) e.y = ta;
        else if (fc == ALU_F_NOT) e.y = ~ta;
        else if (fc == ALU_F_AND) e.y = ta & tb;
        else if (fc == ALU_F_OR)  e.y = ta | tb;
        else if (fc == ALU_F_XOR) e.y = ta ^ tb;
        else if (fc == ALU_F_ADD) begin
          r   = longint'(ta) + longint'(tb) + longint'(ci);
          e.y = r[15:0];
          e.c = r[16];
          sr  = int'($signed(ta)) + int'($signed(tb)) + int'(ci);
          e.v = (sr > 32767) || (sr < -32768);
        end else if (fc == ALU_F_SUB) begin
          r   = longint'(ta) + (65535 - longint'(tb)) + longint'(ci);
          e.y = r[15:0];
          e.c = r[16];
          sr  = int'($signed(ta)) - int'($signed(tb)) - 1 + int'(ci);
          e.v = (sr > 32767) || (sr < -32768);
        end else e.e = 1'b1;
      end
      ALU_MODE_SHIFT: begin
        if (fc == ALU_F_SHIFT_SHL) begin
          e.y = ta << s;
          e.c = (s == 0) ? 1'b0 : ta[16-s];
        end else if (fc == ALU_F_SHIFT_SHR) begin
          e.y = ta >> s;
          e.c = (s == 0) ? 1'b0 : ta[s-1];
        end else e.e = 1'b1;
      end
      ALU_MODE_MUL: begin
        r    = longint'(ta) * longint'(tb);
        e.y  = r[15:0];
        e.hi = r[31:16];
        e.c  = (e.hi != 16'd0);
      end
      default: e.e = 1'b1;
    endcase
    e.z = ({e.hi, e.y} == 32'd0);
    e.n = (m == ALU_MODE_MUL) ? e.hi[15] : e.y[15];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input exp_t e);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_y"},    32'(y),    32'(e.y));
    chk({tag, "_hi"},   32'(hi),   32'(e.hi));
    chk({tag, "_cout"}, 32'(cout), 32'(e.c));
    chk({tag, "_zout"}, 32'(zout), 32'(e.z));
    chk({tag, "_vout"}, 32'(vout), 32'(e.v));
    chk({tag, "_nout"}, 32'(nout), 32'(e.n));
    chk({tag, "_err"},  32'(err),  32'(e.e));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_y"},    32'(y),    32'd0);
    chk({tag, "_hi"},   32'(hi),   32'd0);
    chk({tag, "_flags"}, 32'({cout, zout, vout, nout, err}), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic run_op(input logic [1:0] m, input logic [4:0] fc, input logic [15:0] ta,
                        input logic [15:0] tb, input logic ci, input string tag);
    @(negedge clk);
    mode = m; f = fc; a = ta; b = tb; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (m == ALU_MODE_MUL) begin
      for (int i = 1; i <= W; i++) begin
        chk({tag, "_mbusy"}, 32'(busy), 32'd1);
        chk({tag, "_mdone"}, 32'(done), 32'd0);
        @(posedge clk); #1;
      end
    end
    chk_res(tag, model(m, fc, ta, tb, ci));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    // Power-up reset
    repeat (2) @(posedge clk);
    #1;
    chk_zero("por");
    @(negedge clk);
    reset = 1'b0;

    run_op(ALU_MODE_LOGIC, ALU_F_ADD, 16'h7FFF, 16'h0001, 1'b0, "add_ovf");
    chk("add_ovf_lit_y", 32'(y), 32'h8000);
    chk("add_ovf_lit_vnc", 32'({vout, nout, cout}), 32'b110);

    // Reset held two cycles while idle
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk_zero("idle_rst");
    @(negedge clk);
    reset = 1'b0;

    run_op(ALU_MODE_LOGIC, ALU_F_ADD, 16'hFFFF, 16'h0001, 1'b0, "add_wrap");
    chk("add_wrap_lit", 32'({y, cout, zout, vout}), {16'h0000, 3'b110});
    @(posedge clk); #1;
    chk("add_wrap_done_once", 32'(done), 32'd0);
    chk("add_wrap_hold", 32'(y), 32'h0000);

    run_op(ALU_MODE_LOGIC, ALU_F_SUB, 16'h0003, 16'h0005, 1'b1, "sub_neg");
    chk("sub_neg_lit", 32'({y, cout, nout}), {16'hFFFE, 2'b01});
    run_op(ALU_MODE_LOGIC, ALU_F_SUB, 16'h0005, 16'h0003, 1'b1, "sub_pos");
    chk("sub_pos_lit", 32'({y, cout}), {16'h0002, 1'b1});
    run_op(ALU_MODE_SHIFT, ALU_F_SHIFT_SHL, 16'h8001, 16'h0001, 1'b0, "shl1");
    chk("shl1_lit", 32'({y, cout}), {16'h0002, 1'b1});
    run_op(ALU_MODE_SHIFT, ALU_F_SHIFT_SHR, 16'h0003, 16'h0001, 1'b0, "shr1");
    chk("shr1_lit", 32'({y, cout}), {16'h0001, 1'b1});
    run_op(ALU_MODE_SHIFT, ALU_F_SHIFT_SHL, 16'hA5C3, 16'h0010, 1'b0, "shl0");
    chk("shl0_lit", 32'({y, cout}), {16'hA5C3, 1'b0});
    run_op(ALU_MODE_SHIFT, ALU_F_SHIFT_SHR, 16'h8001, 16'h0000, 1'b1, "shr0");
    chk("shr0_lit", 32'({y, cout}), {16'h8001, 1'b0});

    // Multiply with a start issued during busy cycle 3, which must be ignored
    @(negedge clk);
    mode = ALU_MODE_MUL; f = 5'd0; a = 16'h1234; b = 16'h0100; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= W; i++) begin
      chk("mul_busy", 32'(busy), 32'd1);
      chk("mul_nodone", 32'(done), 32'd0);
      if (i == 3) begin
        start = 1'b1; mode = ALU_MODE_LOGIC; f = ALU_F_ADD; a = 16'h0001; b = 16'h0001;
      end
      if (i == 4) start = 1'b0;
      @(posedge clk); #1;
    end
    chk_res("mul", model(ALU_MODE_MUL, 5'd0, 16'h1234, 16'h0100, 1'b0));
    chk("mul_lit", 32'({hi, y}), 32'h0012_3400);
    chk("mul_lit_cout", 32'(cout), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mul_after_done", 32'(done), 32'd0);
      chk("mul_after_hold", 32'({hi, y}), 32'h0012_3400);
    end

    // Reset during busy cycle 5 aborts the multiply
    @(negedge clk);
    mode = ALU_MODE_MUL; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      chk("abort_busy", 32'(busy), 32'd1);
      if (i < 5) begin
        @(posedge clk); #1;
      end
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_zero("abort");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("abort_nodone", 32'({busy, done}), 32'd0);
    end
    run_op(ALU_MODE_RSVD, 5'd0, 16'h5A5A, 16'h1111, 1'b1, "rsvd");
    chk("rsvd_lit", 32'({err, y, hi}), {1'b1, 16'h5A5A, 16'h0000});
    run_op(ALU_MODE_LOGIC, 5'h1F, 16'h8000, 16'h1111, 1'b0, "badf");
    chk("badf_lit", 32'({err, y, nout}), {1'b1, 16'h8000, 1'b1});

    // Randomized operations, all modes, one at a time
    for (int k = 0; k < 30; k++) begin
      logic [1:0]  rm;
      logic [4:0]  rf;
      rm = 2'($urandom_range(0, 3));
      rf = 5'($urandom);
      if (rm == ALU_MODE_LOGIC) rf = 5'($urandom_range(0, 7));
      if (rm == ALU_MODE_SHIFT) rf = 5'($urandom_range(0, 1));
      run_op(rm, rf, 16'($urandom), 16'($urandom), 1'($urandom), "rnd");
    end

    // Back-to-back single-cycle operations with start held high
    for (int k = 0; k < 25; k++) begin
      logic [1:0]  rm;
      logic [4:0]  rf;
      int          sel;
      sel = $urandom_range(0, 2);
      rm  = (sel == 0) ? ALU_MODE_LOGIC : (sel == 1) ? ALU_MODE_SHIFT : ALU_MODE_RSVD;
      rf  = (rm == ALU_MODE_SHIFT) ? 5'($urandom_range(0, 1)) : 5'($urandom_range(0, 7));
      @(negedge clk);
      mode = rm; f = rf; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      start = 1'b1;
      @(posedge clk); #1;
      e = model(rm, rf, a, b, cin);
      chk_res("b2b", e);
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_end_done", 32'(done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
